// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared constants for the main-memory responder slice.
//   MEM_DATA_BITS    : width of one memory beat
//   CPU_ADDR_BITS    : CPU byte-address width
//   BURST_LEN        : beats returned per read request (fixed)
//   LAT_CNT_BITS     : width of the read-latency counter
//   MAX_READ_LATENCY : largest READ_LATENCY the counter can express
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   localparam int MEM_DATA_BITS    = 128;
   localparam int CPU_ADDR_BITS    = 32;
   localparam int BURST_LEN        = 4;
   localparam int LAT_CNT_BITS     = 4;
   localparam int MAX_READ_LATENCY = 15;

   // Beat offset inside an aligned 4-beat block. The 2-bit sum wraps mod 4,
   // so a burst starting at offset 2 visits 2,3,0,1.
   function automatic logic [1:0] beat_offset(input logic [1:0] base,
                                              input logic [1:0] beat);
      return base + beat;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Cache-to-memory port: request, write-data and read-response channels.
//   mem_req_valid/ready/addr/rw          : request handshake (rw 1 = write)
//   mem_req_data_valid/ready/bits/mask   : write-data beat with byte enables
//   mem_resp_valid/data                  : read beat, no back-pressure
// Modports: master = cache side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = MEM_DATA_BITS
) ();

   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [ADDR_BITS-1:0]   mem_req_addr;
   logic                   mem_req_rw;
   logic                   mem_req_data_valid;
   logic                   mem_req_data_ready;
   logic [DATA_BITS-1:0]   mem_req_data_bits;
   logic [DATA_BITS/8-1:0] mem_req_data_mask;
   logic                   mem_resp_valid;
   logic [DATA_BITS-1:0]   mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
   );

endinterface

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_responder_array
// 2^DEPTH_BITS x DATA_BITS beat storage, one write and one read per cycle.
//   clk, reset  : clock, synchronous active-high reset (read register only)
//   i_wr_en     : write strobe
//   i_wr_addr   : write beat index
//   i_wr_data   : write data
//   i_wr_mask   : byte enables, bit i covers data[8i+7:8i]
//   i_rd_en     : read strobe, loads the output register
//   i_rd_addr   : read beat index
//   o_rd_data   : registered read data, holds between reads
// -----------------------------------------------------------------------------
module mem_responder_array #(
   parameter int DATA_BITS  = 128,
   parameter int DEPTH_BITS = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_wr_en,
   input  logic [DEPTH_BITS-1:0]  i_wr_addr,
   input  logic [DATA_BITS-1:0]   i_wr_data,
   input  logic [DATA_BITS/8-1:0] i_wr_mask,
   input  logic                   i_rd_en,
   input  logic [DEPTH_BITS-1:0]  i_rd_addr,
   output logic [DATA_BITS-1:0]   o_rd_data
);

   localparam int BYTES = DATA_BITS / 8;

   logic [DATA_BITS-1:0] r_mem [2**DEPTH_BITS];
   logic [DATA_BITS-1:0] r_rd_data;

   // NOTE: the storage array has no reset; clearing thousands of entries is
   // not wanted, and contents must survive a reset pulse.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (i_wr_mask[b]) r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)        r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Main-memory responder: accepts one request at a time, stores masked write
// beats, and answers each read with a fixed-latency, wrapping 4-beat burst.
//   clk   : the only clock
//   reset : synchronous, active-high
//   mem   : mem_responder_if slave port (request, write data, read response)
// Parameters: DATA_BITS beat width, ADDR_BITS beat-address width, DEPTH_BITS
// array index width (upper address bits alias), READ_LATENCY 1..15, BURST 4.
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_BITS    = MEM_DATA_BITS,
   parameter int ADDR_BITS    = 28,
   parameter int DEPTH_BITS   = 12,
   parameter int READ_LATENCY = 4,
   parameter int BURST        = 4
) (
   input logic            clk,
   input logic            reset,
   mem_responder_if.slave mem
);

   generate
      if (BURST != BURST_LEN) begin : g_bad_burst
         $error("mem_responder: BURST must be %0d", BURST_LEN);
      end
      if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
         $error("mem_responder: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
      end
      if (DEPTH_BITS < 3 || DEPTH_BITS > ADDR_BITS) begin : g_bad_depth
         $error("mem_responder: DEPTH_BITS must be 3..ADDR_BITS");
      end
      // Address bits above the array index alias by design.
      if (ADDR_BITS > DEPTH_BITS) begin : g_addr_alias
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^mem.mem_req_addr[ADDR_BITS-1:DEPTH_BITS];
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_W_DATA,
      ST_R_WAIT,
      ST_R_BURST
   } state_t;

   // The counter is loaded with READ_LATENCY-1 and the first beat is issued
   // on the edge where it steps from 1 to 0, so the beat appears
   // READ_LATENCY cycles after the accepting edge.
   localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD = LAT_CNT_BITS'(READ_LATENCY - 1);

   state_t                  r_state;
   logic [DEPTH_BITS-1:0]   r_addr;
   logic [LAT_CNT_BITS-1:0] r_lat_cnt;
   logic [1:0]              r_beat;
   logic                    r_req_ready;
   logic                    r_data_ready;
   logic                    r_resp_valid;

   logic                    w_accept;
   logic                    w_first_beat;
   logic                    w_rd_en;
   logic                    w_wr_en;
   logic [DEPTH_BITS-1:0]   w_rd_base;
   logic [1:0]              w_rd_beat;
   logic [DEPTH_BITS-1:0]   w_rd_idx;
   logic [DATA_BITS-1:0]    w_rd_data;

   // NOTE: every signal gets a value before any condition so no latch is
   // inferred in this combinational block.
   always_comb begin
      w_accept     = mem.mem_req_valid & r_req_ready;
      w_first_beat = 1'b0;
      // Latency 1 has no wait state: beat 0 is read on the accepting edge.
      if (r_state == ST_IDLE && w_accept && !mem.mem_req_rw && READ_LATENCY == 1)
         w_first_beat = 1'b1;
      if (r_state == ST_R_WAIT && r_lat_cnt == LAT_CNT_BITS'(1))
         w_first_beat = 1'b1;
      w_rd_en   = w_first_beat | (r_state == ST_R_BURST);
      // In IDLE the address has not been latched yet, so take it from the bus.
      w_rd_base = (r_state == ST_IDLE) ? mem.mem_req_addr[DEPTH_BITS-1:0] : r_addr;
      w_rd_beat = (r_state == ST_R_BURST) ? r_beat : 2'd0;
      w_rd_idx  = {w_rd_base[DEPTH_BITS-1:2], beat_offset(w_rd_base[1:0], w_rd_beat)};
      // Reset abandons a pending write even if data arrives on the same edge.
      w_wr_en   = (r_state == ST_W_DATA) & mem.mem_req_data_valid & ~reset;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_lat_cnt    <= '0;
         r_beat       <= '0;
         r_req_ready  <= 1'b0;
         r_data_ready <= 1'b0;
         r_resp_valid <= 1'b0;
      end else begin
         r_resp_valid <= w_rd_en;
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= 1'b1;
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_addr      <= mem.mem_req_addr[DEPTH_BITS-1:0];
                  if (mem.mem_req_rw) begin
                     r_data_ready <= 1'b1;
                     r_state      <= ST_W_DATA;
                  end else if (READ_LATENCY == 1) begin
                     r_beat  <= 2'd1;
                     r_state <= ST_R_BURST;
                  end else begin
                     r_lat_cnt <= LAT_LOAD;
                     r_state   <= ST_R_WAIT;
                  end
               end
            end
            ST_W_DATA: begin
               if (mem.mem_req_data_valid) begin
                  r_data_ready <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            ST_R_WAIT: begin
               r_lat_cnt <= r_lat_cnt - LAT_CNT_BITS'(1);
               if (r_lat_cnt == LAT_CNT_BITS'(1)) begin
                  r_beat  <= 2'd1;
                  r_state <= ST_R_BURST;
               end
            end
            ST_R_BURST: begin
               // r_beat wraps back to 0 after beat 3. Returning through IDLE
               // with ready still low drops valid and raises ready together.
               r_beat <= r_beat + 2'd1;
               if (r_beat == 2'd3) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   mem_responder_array #(
      .DATA_BITS  (DATA_BITS),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_addr),
      .i_wr_data (mem.mem_req_data_bits),
      .i_wr_mask (mem.mem_req_data_mask),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_idx),
      .o_rd_data (w_rd_data)
   );

   assign mem.mem_req_ready      = r_req_ready;
   assign mem.mem_req_data_ready = r_data_ready;
   assign mem.mem_resp_valid     = r_resp_valid;
   assign mem.mem_resp_data      = w_rd_data;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. Three instances: READ_LATENCY 4
// (main), 1 and 15. Expected data comes from a beat-array model updated on
// every completed write; expected timing comes from the cycle offsets of the
// read and write handshakes.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int AW    = 28;
   localparam int DW    = 128;
   localparam int DEPTH = 4096;

   logic clk;
   logic reset;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] init_mem  [DEPTH];

   mem_responder_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus_m   ();
   mem_responder_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus_l1  ();
   mem_responder_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus_l15 ();

   mem_responder #(.READ_LATENCY(4))  u_dut     (.clk(clk), .reset(reset), .mem(bus_m));
   mem_responder #(.READ_LATENCY(1))  u_dut_l1  (.clk(clk), .reset(reset), .mem(bus_l1));
   mem_responder #(.READ_LATENCY(15)) u_dut_l15 (.clk(clk), .reset(reset), .mem(bus_l15));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Array index of beat j of a burst: low 12 address bits, offset wraps mod 4.
   function automatic int beat_index(input logic [AW-1:0] addr, input int j);
      return (int'(addr[11:0]) & ~3) | ((int'(addr[1:0]) + j) % 4);
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (bus_m.mem_req_ready === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_ready: req_ready=%b still not 1 after 64 cycles", bus_m.mem_req_ready);
   endtask

   // Read burst on the main DUT, checking every cycle from T+1 to T+8.
   task automatic do_read(input logic [AW-1:0] addr, input string tag,
                          output logic [DW-1:0] got [4]);
      bit ok;
      logic exp_v, exp_r;
      wait_ready(ok);
      for (int j = 0; j < 4; j++) got[j] = 'x;
      if (!ok) return;
      bus_m.mem_req_valid = 1'b1;
      bus_m.mem_req_rw    = 1'b0;
      bus_m.mem_req_addr  = addr;
      @(negedge clk);
      bus_m.mem_req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         exp_v = (k >= 4 && k <= 7);
         exp_r = (k == 8);
         n_vec++;
         if (bus_m.mem_resp_valid !== exp_v || bus_m.mem_req_ready !== exp_r ||
             bus_m.mem_req_data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s timing T+%0d: valid=%b ready=%b data_ready=%b, expected valid=%b ready=%b data_ready=0",
                     tag, k, bus_m.mem_resp_valid, bus_m.mem_req_ready,
                     bus_m.mem_req_data_ready, exp_v, exp_r);
         end
         if (exp_v) begin
            got[k-4] = bus_m.mem_resp_data;
            n_vec++;
            if (bus_m.mem_resp_data !== model_mem[beat_index(addr, k-4)]) begin
               n_err++;
               $display("FAIL %s beat %0d: data=%h expected %h", tag, k-4,
                        bus_m.mem_resp_data, model_mem[beat_index(addr, k-4)]);
            end
         end
         if (k < 8) @(negedge clk);
      end
   endtask

   // Write on the main DUT; data_valid is raised 'lag' cycles after accept.
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] mask, input int lag, input string tag);
      bit ok;
      int idx;
      wait_ready(ok);
      if (!ok) return;
      bus_m.mem_req_valid = 1'b1;
      bus_m.mem_req_rw    = 1'b1;
      bus_m.mem_req_addr  = addr;
      @(negedge clk);
      bus_m.mem_req_valid = 1'b0;
      bus_m.mem_req_rw    = 1'b0;
      for (int k = 1; k <= lag; k++) begin
         n_vec++;
         if (bus_m.mem_req_data_ready !== 1'b1 || bus_m.mem_req_ready !== 1'b0 ||
             bus_m.mem_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s wait T+%0d: data_ready=%b ready=%b valid=%b, expected 1 0 0",
                     tag, k, bus_m.mem_req_data_ready, bus_m.mem_req_ready, bus_m.mem_resp_valid);
         end
         if (k < lag) @(negedge clk);
      end
      bus_m.mem_req_data_valid = 1'b1;
      bus_m.mem_req_data_bits  = data;
      bus_m.mem_req_data_mask  = mask;
      @(negedge clk);
      bus_m.mem_req_data_valid = 1'b0;
      idx = int'(addr[11:0]);
      for (int b = 0; b < DW/8; b++)
         if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      n_vec++;
      if (bus_m.mem_req_ready !== 1'b1 || bus_m.mem_req_data_ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s done: ready=%b data_ready=%b, expected 1 0",
                  tag, bus_m.mem_req_ready, bus_m.mem_req_data_ready);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus_m.mem_req_ready !== 1'b0 || bus_m.mem_req_data_ready !== 1'b0 ||
          bus_m.mem_resp_valid !== 1'b0 || bus_m.mem_resp_data !== '0) begin
         n_err++;
         $display("FAIL reset_values: ready=%b data_ready=%b valid=%b data=%h, expected all 0",
                  bus_m.mem_req_ready, bus_m.mem_req_data_ready,
                  bus_m.mem_resp_valid, bus_m.mem_resp_data);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus_m.mem_req_ready !== 1'b1 || bus_m.mem_resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b, expected 1 0",
                  bus_m.mem_req_ready, bus_m.mem_resp_valid);
      end
   endtask

   task automatic test_read_burst;
      logic [DW-1:0] got [4];
      for (int j = 0; j < 4; j++) begin
         model_mem[16'h40 + j] = {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'hA0 + 32'(j)};
         u_dut.u_array.r_mem[16'h40 + j] <= model_mem[16'h40 + j];
      end
      @(negedge clk);
      do_read(28'h40, "read_burst", got);
      do_read(28'h42, "wrap_burst", got);
   endtask

   task automatic test_masked_write;
      logic [DW-1:0] got [4];
      model_mem[5] = '1;
      u_dut.u_array.r_mem[5] <= '1;
      @(negedge clk);
      do_write(28'h5, '0, 16'h00F0, 1, "masked_write");
      do_read(28'h4, "masked_read", got);
      n_vec++;
      if (got[1] !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) begin
         n_err++;
         $display("FAIL masked_beat1: data=%h expected FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF", got[1]);
      end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] got [4];
      logic [DW-1:0] wdata [4];
      for (int j = 0; j < 4; j++) begin
         wdata[j] = rand_beat();
         do_write(28'h80 + AW'(j), wdata[j], 16'hFFFF, 1, "evict_write");
      end
      do_read(28'h80, "evict_read", got);
      for (int j = 0; j < 4; j++) begin
         n_vec++;
         if (got[j] !== wdata[j]) begin
            n_err++;
            $display("FAIL evict_beat%0d: data=%h expected %h", j, got[j], wdata[j]);
         end
      end
   endtask

   task automatic test_stray_data;
      logic [DW-1:0] got [4];
      for (int i = 0; i < 3; i++) begin
         bus_m.mem_req_data_valid = 1'b1;
         bus_m.mem_req_data_bits  = rand_beat();
         bus_m.mem_req_data_mask  = 16'hFFFF;
         @(negedge clk);
         n_vec++;
         if (bus_m.mem_req_data_ready !== 1'b0 || bus_m.mem_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stray_idle: data_ready=%b ready=%b, expected 0 1",
                     bus_m.mem_req_data_ready, bus_m.mem_req_ready);
         end
      end
      bus_m.mem_req_data_valid = 1'b0;
      do_read(28'h80, "stray_read", got);
   endtask

   task automatic test_reset_midflight;
      bit ok;
      logic [DW-1:0] got [4];
      // Reset while beat 1 of a burst is on the bus.
      wait_ready(ok);
      bus_m.mem_req_valid = 1'b1;
      bus_m.mem_req_rw    = 1'b0;
      bus_m.mem_req_addr  = 28'h80;
      @(negedge clk);
      bus_m.mem_req_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if (bus_m.mem_resp_valid !== 1'b1 || bus_m.mem_resp_data !== model_mem[16'h81]) begin
         n_err++;
         $display("FAIL midburst_beat1: valid=%b data=%h expected 1 %h",
                  bus_m.mem_resp_valid, bus_m.mem_resp_data, model_mem[16'h81]);
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus_m.mem_resp_valid !== 1'b0 || bus_m.mem_req_ready !== 1'b0 ||
          bus_m.mem_resp_data !== '0) begin
         n_err++;
         $display("FAIL midburst_reset: valid=%b ready=%b data=%h, expected 0 0 0",
                  bus_m.mem_resp_valid, bus_m.mem_req_ready, bus_m.mem_resp_data);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus_m.mem_req_ready !== 1'b1 || bus_m.mem_resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midburst_release: ready=%b valid=%b, expected 1 0",
                  bus_m.mem_req_ready, bus_m.mem_resp_valid);
      end
      // Reset while a write waits for data; data arriving on the reset edge is dropped.
      bus_m.mem_req_valid = 1'b1;
      bus_m.mem_req_rw    = 1'b1;
      bus_m.mem_req_addr  = 28'h40;
      @(negedge clk);
      bus_m.mem_req_valid      = 1'b0;
      bus_m.mem_req_rw         = 1'b0;
      reset                    = 1'b1;
      bus_m.mem_req_data_valid = 1'b1;
      bus_m.mem_req_data_bits  = ~model_mem[16'h40];
      bus_m.mem_req_data_mask  = 16'hFFFF;
      @(negedge clk);
      bus_m.mem_req_data_valid = 1'b0;
      reset                    = 1'b0;
      n_vec++;
      if (bus_m.mem_req_data_ready !== 1'b0) begin
         n_err++;
         $display("FAIL wdata_reset: data_ready=%b expected 0", bus_m.mem_req_data_ready);
      end
      @(negedge clk);
      do_read(28'h40, "after_reset_read", got);
      do_read(28'h80, "kept_write_read", got);
   endtask

   task automatic test_random;
      logic [DW-1:0] got [4];
      logic [AW-1:0] addr;
      for (int n = 0; n < 40; n++) begin
         // Random upper bits exercise aliasing; low bits stay in a small window
         // so reads often hit recently written beats.
         addr = {AW'($urandom) & ~AW'(12'hFFF)} | AW'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1)
            do_write(addr, rand_beat(), 16'($urandom), int'($urandom_range(1, 3)), "rand_write");
         else
            do_read(addr, "rand_read", got);
      end
   endtask

   task automatic sw_drive(input int w, input logic v, input logic [AW-1:0] a);
      if (w == 1) begin
         bus_l1.mem_req_valid = v;  bus_l1.mem_req_addr = a;  bus_l1.mem_req_rw = 1'b0;
      end else begin
         bus_l15.mem_req_valid = v; bus_l15.mem_req_addr = a; bus_l15.mem_req_rw = 1'b0;
      end
   endtask

   task automatic sweep_read(input int w, input int lat, input logic [AW-1:0] addr);
      logic rdy, vld, exp_v, exp_r;
      logic [DW-1:0] dat;
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         rdy = (w == 1) ? bus_l1.mem_req_ready : bus_l15.mem_req_ready;
         if (rdy === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL sweep_L%0d ready: not ready within 64 cycles", lat);
         return;
      end
      sw_drive(w, 1'b1, addr);
      @(negedge clk);
      sw_drive(w, 1'b0, addr);
      for (int k = 1; k <= lat + 4; k++) begin
         vld   = (w == 1) ? bus_l1.mem_resp_valid : bus_l15.mem_resp_valid;
         rdy   = (w == 1) ? bus_l1.mem_req_ready  : bus_l15.mem_req_ready;
         dat   = (w == 1) ? bus_l1.mem_resp_data  : bus_l15.mem_resp_data;
         exp_v = (k >= lat && k <= lat + 3);
         exp_r = (k == lat + 4);
         n_vec++;
         if (vld !== exp_v || rdy !== exp_r ||
             (exp_v && dat !== init_mem[beat_index(addr, k - lat)])) begin
            n_err++;
            $display("FAIL sweep_L%0d T+%0d: valid=%b ready=%b data=%h, expected valid=%b ready=%b data=%h",
                     lat, k, vld, rdy, dat, exp_v, exp_r,
                     exp_v ? init_mem[beat_index(addr, k - lat)] : '0);
         end
         if (k < lat + 4) @(negedge clk);
      end
   endtask

   task automatic test_latency_sweep;
      sweep_read(1, 1, 28'h40);
      sweep_read(1, 1, AW'($urandom));
      sweep_read(2, 15, 28'h42);
      sweep_read(2, 15, AW'($urandom));
   endtask

   initial begin
      reset = 1'b1;
      bus_m.mem_req_valid = 1'b0;   bus_m.mem_req_addr = '0;   bus_m.mem_req_rw = 1'b0;
      bus_m.mem_req_data_valid = 1'b0; bus_m.mem_req_data_bits = '0; bus_m.mem_req_data_mask = '0;
      bus_l1.mem_req_valid = 1'b0;  bus_l1.mem_req_addr = '0;  bus_l1.mem_req_rw = 1'b0;
      bus_l1.mem_req_data_valid = 1'b0; bus_l1.mem_req_data_bits = '0; bus_l1.mem_req_data_mask = '0;
      bus_l15.mem_req_valid = 1'b0; bus_l15.mem_req_addr = '0; bus_l15.mem_req_rw = 1'b0;
      bus_l15.mem_req_data_valid = 1'b0; bus_l15.mem_req_data_bits = '0; bus_l15.mem_req_data_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         init_mem[i]  = rand_beat();
         model_mem[i] = init_mem[i];
         u_dut.u_array.r_mem[i]     <= init_mem[i];
         u_dut_l1.u_array.r_mem[i]  <= init_mem[i];
         u_dut_l15.u_array.r_mem[i] <= init_mem[i];
      end
      test_reset();
      test_read_burst();
      test_masked_write();
      test_back_to_back();
      test_stray_data();
      test_reset_midflight();
      test_random();
      test_latency_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
